// File: rtl/pool_stream.sv
// Purpose : streaming channel-parallel KxK non-overlapping pooling (max or floor-average) over a row-major frame.
// Latency : pooled pixel is presented one cycle after the input transfer that completes its window.
// Backpr. : non-completing beats are always accepted; a completing beat stalls only while the output register is full and not drained.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   mode               0 = max, 1 = average; captured on the first beat of each frame
//   in_valid/in_ready  input handshake; in_data packs CH signed samples, ch c at [c*DATA_W +: DATA_W]
//   out_valid/out_ready output handshake; out_data uses the same packing
//   out_last           marks the pooled pixel of the window holding the frame's last input pixel

module pool_stream #(
    parameter int DATA_W = 8,
    parameter int CH     = 4,
    parameter int POOL_K = 2,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CH*DATA_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH*DATA_W-1:0]   out_data,
    output logic                   out_last
);

    // POOL_K is a power of two, so window position and window index come
    // straight from the low / high bits of the pixel counters.
    localparam int LOG_K = $clog2(POOL_K);
    localparam int SHIFT = 2 * LOG_K;              // divide by K*K
    localparam int ACC_W = DATA_W + SHIFT;         // holds a K*K sum without overflow
    localparam int NWIN  = IMG_W / POOL_K;         // windows across one row band
    localparam int IW    = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    if ((IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0 ||
        POOL_K < 2 || (POOL_K & (POOL_K - 1)) != 0) begin : g_param_check
        $error("pool_stream: POOL_K must be a power of two >= 2 dividing IMG_W and IMG_H");
    end

    // ------------------------------------------------------------------
    // Position tracking
    // ------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          mode_q;

    logic          in_fire;
    logic          out_fire;
    logic          frame_start;
    logic          frame_done;
    logic          win_first;
    logic          win_done;
    logic          mode_eff;
    logic [IW-1:0] win_idx;

    assign frame_start = (row == '0) && (col == '0);
    assign frame_done  = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign win_first   = (row[LOG_K-1:0] == '0) && (col[LOG_K-1:0] == '0);
    assign win_done    = (row[LOG_K-1:0] == {LOG_K{1'b1}}) &&
                         (col[LOG_K-1:0] == {LOG_K{1'b1}});
    assign win_idx     = IW'(col >> LOG_K);

    // The beat that starts a frame carries the mode for the whole frame, so
    // it must take effect on that same beat rather than after the latch.
    assign mode_eff    = frame_start ? mode : mode_q;

    // Only a completing beat needs the output register; everything else
    // just updates the accumulator bank. A draining output frees the
    // register in the same cycle, so reload happens without a bubble.
    assign in_ready    = !(win_done && out_valid && !out_ready);
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Accumulator bank: one entry per window column, CH lanes each
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc     [2**IW][CH];
    logic signed [ACC_W-1:0] sample  [CH];
    logic signed [ACC_W-1:0] acc_nxt [CH];
    logic signed [ACC_W-1:0] avg     [CH];
    logic [CH*DATA_W-1:0]    pooled;

    always_comb begin
        pooled = '0;
        for (int c = 0; c < CH; c++) begin
            sample[c]  = '0;
            acc_nxt[c] = '0;
            avg[c]     = '0;
        end
        for (int c = 0; c < CH; c++) begin
            sample[c] = {{SHIFT{in_data[c*DATA_W + DATA_W - 1]}},
                         in_data[c*DATA_W +: DATA_W]};
            if (win_first) begin
                acc_nxt[c] = sample[c];
            end else if (!mode_eff) begin
                acc_nxt[c] = (sample[c] > acc[win_idx][c]) ? sample[c] : acc[win_idx][c];
            end else begin
                acc_nxt[c] = acc[win_idx][c] + sample[c];
            end
            // Arithmetic shift floors toward minus infinity, which is the
            // rounding the average output is defined with.
            avg[c] = acc_nxt[c] >>> SHIFT;
            // A max result always fits back into DATA_W; so does the
            // shifted sum, since it lies between the window min and max.
            pooled[c*DATA_W +: DATA_W] = mode_eff ? avg[c][DATA_W-1:0]
                                                  : acc_nxt[c][DATA_W-1:0];
        end
    end

    // Accumulator contents after reset are irrelevant: every window's first
    // pixel overwrites its entry before anything reads it.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int c = 0; c < CH; c++) begin
                acc[win_idx][c] <= acc_nxt[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters, mode latch and output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                if (frame_start) begin
                    mode_q <= mode;
                end
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            if (in_fire && win_done) begin
                out_valid <= 1'b1;
                out_data  <= pooled;
                out_last  <= frame_done;
            end else if (out_fire) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
